// File: rtl/control_multiciclo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : jericalla_pkg                                                 |
// | Purpose : Shared encodings for the Jericalla multicycle control stage:  |
// |           ALU operation codes, MIPS R-type funct/opcode constants and   |
// |           the controller FSM state type.                                |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package jericalla_pkg;

  // ALU operation codes driven on alu_op_ctrl
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  // Supported R-type funct fields
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/control_multiciclo_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : control_multiciclo_if                                       |
// | Purpose   : Bundles the instruction-memory handshake and the register   |
// |             bank / ALU connections of the multicycle controller.        |
// | Signals   : imem_req/imem_addr/imem_ack/imem_data  - fetch handshake    |
// |             ra1_ctrl/ra2_ctrl/alu_op_ctrl/alu_res   - read + ALU path   |
// |             wa_ctrl/dw_ctrl/we_ctrl                 - bank write port   |
// | Modports  : master = controller side, slave = memory/bank/ALU side      |
// | Rev       : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface control_multiciclo_if #(
  parameter int ADDR_W = 8
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_data;
  logic [4:0]        ra1_ctrl;
  logic [4:0]        ra2_ctrl;
  logic [3:0]        alu_op_ctrl;
  logic [31:0]       alu_res;
  logic [4:0]        wa_ctrl;
  logic [31:0]       dw_ctrl;
  logic              we_ctrl;

  modport master (
    output imem_req, imem_addr, ra1_ctrl, ra2_ctrl, alu_op_ctrl,
           wa_ctrl, dw_ctrl, we_ctrl,
    input  imem_ack, imem_data, alu_res
  );

  modport slave (
    input  imem_req, imem_addr, ra1_ctrl, ra2_ctrl, alu_op_ctrl,
           wa_ctrl, dw_ctrl, we_ctrl,
    output imem_ack, imem_data, alu_res
  );

endinterface
`default_nettype wire

// File: rtl/control_multiciclo_decodificador_r.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : decodificador_r                                               |
// | Purpose : Combinational R-type decoder: opcode/funct -> legal, alu_op.  |
// | Ports   : opcode (in, 6)  instruction bits [31:26]                      |
// |           funct  (in, 6)  instruction bits [5:0]                        |
// |           legal  (out, 1) instruction is a supported R-type op          |
// |           alu_op (out, 4) ALU operation code                            |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module decodificador_r
  import jericalla_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       legal,
  output logic [3:0] alu_op
);

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    if (opcode == OPCODE_RTYPE) begin
      case (funct)
        FUNCT_ADD: begin legal = 1'b1; alu_op = ALU_ADD; end
        FUNCT_SUB: begin legal = 1'b1; alu_op = ALU_SUB; end
        FUNCT_AND: begin legal = 1'b1; alu_op = ALU_AND; end
        FUNCT_OR:  begin legal = 1'b1; alu_op = ALU_OR;  end
        FUNCT_SLT: begin legal = 1'b1; alu_op = ALU_SLT; end
        default:   begin legal = 1'b0; alu_op = ALU_ADD; end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_multiciclo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : control_multiciclo                                            |
// | Purpose : Multicycle control stage of the Jericalla datapath. Fetches   |
// |           R-type instructions over a REQ/ACK handshake, decodes them,   |
// |           drives bank read addresses and ALU op, captures the ALU       |
// |           result and writes it back to the register bank.               |
// | Ports   : clk, rst_n (async, active-low)                                |
// |           start_ctrl   (in)  start/restart, honoured in IDLE/HALT only  |
// |           bus          (master) imem handshake + bank/ALU signals       |
// |           busy_ctrl    (out) high from FETCH to WRITEBACK               |
// |           illegal_ctrl (out) sticky, unsupported instruction halted us  |
// |           instr_count  (out) instructions retired since last start     |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module control_multiciclo
  import jericalla_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PC_STEP  = 4,
  parameter int PROG_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_ctrl,
  control_multiciclo_if.master bus,
  output logic                 busy_ctrl,
  output logic                 illegal_ctrl,
  output logic [15:0]          instr_count
);

  localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(PC_STEP);
  localparam logic [15:0]       c_prog_len = 16'(PROG_LEN);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_req;
  logic [4:0]        r_ra1;
  logic [4:0]        r_ra2;
  logic [3:0]        r_alu_op;
  logic [4:0]        r_wa;
  logic [31:0]       r_dw;
  logic              r_we;
  logic              r_busy;
  logic              r_illegal;
  logic [15:0]       r_count;

  logic              w_legal;
  logic [3:0]        w_alu_op;
  logic [15:0]       w_count_next;
  logic              w_unused;

  decodificador_r u_dec (
    .opcode (r_ir[31:26]),
    .funct  (r_ir[5:0]),
    .legal  (w_legal),
    .alu_op (w_alu_op)
  );

  assign w_count_next = r_count + 16'd1;

  // shamt is not used by any supported operation
  assign w_unused = &{1'b0, r_ir[10:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_req     <= 1'b0;
      r_ra1     <= '0;
      r_ra2     <= '0;
      r_alu_op  <= '0;
      r_wa      <= '0;
      r_dw      <= '0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      // write enable is a one-cycle pulse armed only from EXECUTE
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (start_ctrl) begin
            r_state   <= ST_FETCH;
            r_pc      <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_req     <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            r_ir    <= bus.imem_data;
            r_req   <= 1'b0;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_ra1    <= r_ir[25:21];
          r_ra2    <= r_ir[20:16];
          r_wa     <= r_ir[15:11];
          r_alu_op <= w_alu_op;
          if (w_legal) begin
            r_state <= ST_EXECUTE;
          end else begin
            r_state   <= ST_HALT;
            r_illegal <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        ST_EXECUTE: begin
          // read addresses have been stable for a full cycle, ALU result is settled
          r_dw    <= bus.alu_res;
          r_we    <= (r_wa != 5'd0);
          r_state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          r_pc    <= r_pc + c_pc_step;
          r_count <= w_count_next;
          if (w_count_next == c_prog_len) begin
            r_state <= ST_HALT;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.ra1_ctrl    = r_ra1;
  assign bus.ra2_ctrl    = r_ra2;
  assign bus.alu_op_ctrl = r_alu_op;
  assign bus.wa_ctrl     = r_wa;
  assign bus.dw_ctrl     = r_dw;
  assign bus.we_ctrl     = r_we;
  assign busy_ctrl       = r_busy;
  assign illegal_ctrl    = r_illegal;
  assign instr_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_control_multiciclo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_control_multiciclo                                         |
// | Purpose : Self-checking bench for control_multiciclo. Acts as IMEM,     |
// |           register bank and ALU; a MIPS-level program model predicts    |
// |           fetch addresses, bank writes, retire count, PC and halt cause.|
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_control_multiciclo;

  localparam int ADDR_W     = 8;
  localparam int PROG_LEN_A = 64;
  localparam int PROG_LEN_B = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [3:0]  op;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start2;
  logic        busy;
  logic        illegal;
  logic [15:0] count;
  logic        busy2;
  logic        illegal2;
  logic [15:0] count2;

  int passed = 0;
  int total  = 0;

  logic [31:0] bank  [32];
  logic [31:0] mregs [32];
  logic [31:0] prog  [64];
  exp_t        exp_q[$];
  logic [7:0]  fetch_q[$];
  int          exp_count;
  logic [7:0]  exp_pc;
  logic        exp_illegal;

  control_multiciclo_if #(.ADDR_W(ADDR_W)) bus ();
  control_multiciclo_if #(.ADDR_W(ADDR_W)) bus2 ();

  control_multiciclo #(.ADDR_W(ADDR_W), .PC_STEP(4), .PROG_LEN(PROG_LEN_A)) dut (
    .clk(clk), .rst_n(rst_n), .start_ctrl(start), .bus(bus),
    .busy_ctrl(busy), .illegal_ctrl(illegal), .instr_count(count)
  );

  control_multiciclo #(.ADDR_W(ADDR_W), .PC_STEP(4), .PROG_LEN(PROG_LEN_B)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_ctrl(start2), .bus(bus2),
    .busy_ctrl(busy2), .illegal_ctrl(illegal2), .instr_count(count2)
  );

  always #5 clk = ~clk;

  // datapath ALU as seen by the controller
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_res = alu_f(bank[bus.ra1_ctrl], bank[bus.ra2_ctrl], bus.alu_op_ctrl);

  // ---------------- reference model (MIPS semantics) ----------------
  function automatic bit is_legal(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
  endfunction

  function automatic logic [31:0] ref_exec(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    case (f)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_op(input logic [5:0] f);
    case (f)
      6'h20:   return 4'd0;
      6'h22:   return 4'd1;
      6'h24:   return 4'd2;
      6'h25:   return 4'd3;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r = $urandom;
    logic [5:0]  f;
    case (r[2:0])
      3'd0, 3'd5: f = 6'h20;
      3'd1, 3'd6: f = 6'h22;
      3'd2, 3'd7: f = 6'h24;
      3'd3:       f = 6'h25;
      default:    f = 6'h2A;
    endcase
    return {6'h00, r[31:12], f};
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] r = $urandom;
    if (r[0]) return {6'h23, r[25:0]};
    return {6'h00, r[25:6], 6'h21};
  endfunction

  task automatic model_build();
    logic [7:0]  pc = 8'd0;
    logic [31:0] ins;
    logic [31:0] v;
    exp_q.delete();
    fetch_q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = bank[i];
    exp_count   = 0;
    exp_illegal = 1'b0;
    for (int k = 0; k < PROG_LEN_A; k++) begin
      fetch_q.push_back(pc);
      ins = prog[pc[7:2]];
      if (!is_legal(ins)) begin
        exp_illegal = 1'b1;
        break;
      end
      v = ref_exec(ins[5:0], mregs[ins[25:21]], mregs[ins[20:16]]);
      if (ins[15:11] != 5'd0) begin
        mregs[ins[15:11]] = v;
        exp_q.push_back('{rd: ins[15:11], rs: ins[25:21], rt: ins[20:16],
                          op: ref_op(ins[5:0]), val: v});
      end
      exp_count++;
      pc = pc + 8'd4;
    end
    exp_pc = pc;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'hFC00_0000;
  endtask

  task automatic init_bank();
    bank[0] = 32'd0;
    for (int i = 1; i < 32; i++) bank[i] = $urandom;
  endtask

  // Starts the main DUT, serves fetches, plays bank, checks everything against the model.
  task automatic run_prog(input string tag, input int wmin, input int wmax, input bit spur);
    int         cyc = 0;
    int         wait_left = 0;
    int         sum_wait = 0;
    int         exp_cyc;
    int         bad;
    bit         prev_we = 1'b0;
    bit         prev_req = 1'b0;
    logic [7:0] prev_addr = 8'd0;
    logic [7:0] exp_a;
    exp_t       e;
    model_build();
    bus.imem_ack = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, illegal, bus.imem_req} !== 3'b101 || count !== 16'd0 || bus.imem_addr !== 8'd0)
      $display("FAIL %s start_state: got busy/illegal/req=%b count=%0d addr=%0d want 101 0 0",
               tag, {busy, illegal, bus.imem_req}, count, bus.imem_addr);
    else passed++;
    while (busy === 1'b1 && cyc < 2000) begin
      if (bus.we_ctrl === 1'b1) begin
        total++;
        if (prev_we) $display("FAIL %s we_width: got WE high 2 cycles want 1", tag);
        else passed++;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s we_unexpected: got write wa=%0d dw=%h want none",
                   tag, bus.wa_ctrl, bus.dw_ctrl);
        end else begin
          e = exp_q.pop_front();
          if ({bus.wa_ctrl, bus.dw_ctrl, bus.ra1_ctrl, bus.ra2_ctrl, bus.alu_op_ctrl} !==
              {e.rd, e.val, e.rs, e.rt, e.op})
            $display("FAIL %s write: got wa=%0d dw=%h ra1=%0d ra2=%0d op=%0d want wa=%0d dw=%h ra1=%0d ra2=%0d op=%0d",
                     tag, bus.wa_ctrl, bus.dw_ctrl, bus.ra1_ctrl, bus.ra2_ctrl, bus.alu_op_ctrl,
                     e.rd, e.val, e.rs, e.rt, e.op);
          else passed++;
        end
        if (bus.wa_ctrl != 5'd0) bank[bus.wa_ctrl] = bus.dw_ctrl;
      end
      if (bus.imem_req === 1'b1) begin
        total++;
        if (!prev_req) begin
          wait_left = $urandom_range(wmax, wmin);
          sum_wait += wait_left;
          if (fetch_q.size() == 0) begin
            $display("FAIL %s fetch_extra: got fetch addr=%0d want none", tag, bus.imem_addr);
          end else begin
            exp_a = fetch_q.pop_front();
            if (bus.imem_addr !== exp_a)
              $display("FAIL %s fetch_addr: got %0d want %0d", tag, bus.imem_addr, exp_a);
            else passed++;
          end
        end else begin
          if (bus.imem_addr !== prev_addr)
            $display("FAIL %s addr_stable: got %0d want %0d", tag, bus.imem_addr, prev_addr);
          else passed++;
        end
        if (wait_left == 0) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = prog[bus.imem_addr[7:2]];
        end else begin
          bus.imem_ack  = 1'b0;
          bus.imem_data = $urandom;
          wait_left--;
        end
      end else begin
        bus.imem_ack  = spur ? 1'($urandom_range(1, 0)) : 1'b0;
        bus.imem_data = $urandom;
      end
      prev_we   = bus.we_ctrl;
      prev_req  = bus.imem_req;
      prev_addr = bus.imem_addr;
      @(negedge clk);
      cyc++;
    end
    bus.imem_ack = 1'b0;
    total++;
    if (cyc >= 2000) $display("FAIL %s timeout: got %0d cycles busy want halt", tag, cyc);
    else passed++;
    exp_cyc = 4 * exp_count + (exp_illegal ? 2 : 0) + sum_wait;
    total++;
    if (cyc != exp_cyc) $display("FAIL %s latency: got %0d cycles want %0d", tag, cyc, exp_cyc);
    else passed++;
    total++;
    if (exp_q.size() != 0 || fetch_q.size() != 0)
      $display("FAIL %s missing: got %0d writes %0d fetches outstanding want 0 0",
               tag, exp_q.size(), fetch_q.size());
    else passed++;
    total++;
    if (count !== 16'(exp_count)) $display("FAIL %s count: got %0d want %0d", tag, count, exp_count);
    else passed++;
    total++;
    if (bus.imem_addr !== exp_pc) $display("FAIL %s pc: got %0d want %0d", tag, bus.imem_addr, exp_pc);
    else passed++;
    total++;
    if (illegal !== exp_illegal) $display("FAIL %s illegal: got %b want %b", tag, illegal, exp_illegal);
    else passed++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (bank[i] !== mregs[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL %s bank: got %0d registers differing want 0", tag, bad);
    else passed++;
    // halted: stray acks must not restart anything
    bad = 0;
    repeat (4) begin
      bus.imem_ack  = 1'b1;
      bus.imem_data = $urandom;
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || busy !== 1'b0 || bus.we_ctrl !== 1'b0 || count !== 16'(exp_count))
        bad++;
    end
    bus.imem_ack = 1'b0;
    total++;
    if (bad != 0) $display("FAIL %s halt_hold: got %0d active cycles want 0", tag, bad);
    else passed++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    start2 = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'h0022_1820;
    bus2.imem_ack = 1'b1;
    bus2.imem_data = 32'h0022_1820;
    bus2.alu_res = 32'h0000_0011;
    bank[0] = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.imem_req, bus.imem_addr, bus.ra1_ctrl, bus.ra2_ctrl, bus.alu_op_ctrl, bus.wa_ctrl,
         bus.dw_ctrl, bus.we_ctrl, busy, illegal, count} !== '0)
      $display("FAIL reset_outputs: got req=%b addr=%0d wa=%0d dw=%h we=%b busy=%b cnt=%0d want all 0",
               bus.imem_req, bus.imem_addr, bus.wa_ctrl, bus.dw_ctrl, bus.we_ctrl, busy, count);
    else passed++;
    total++;
    if ({bus2.imem_req, bus2.imem_addr, bus2.we_ctrl, busy2, illegal2, count2} !== '0)
      $display("FAIL reset_outputs2: got req=%b addr=%0d we=%b busy=%b cnt=%0d want all 0",
               bus2.imem_req, bus2.imem_addr, bus2.we_ctrl, busy2, count2);
    else passed++;
    start = 1'b0;
    start2 = 1'b0;
    bus.imem_ack = 1'b0;
    bus2.imem_ack = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, bus.imem_req, busy2, bus2.imem_req} !== 4'b0000)
      $display("FAIL idle_after_reset: got busy/req/busy2/req2=%b want 0000",
               {busy, bus.imem_req, busy2, bus2.imem_req});
    else passed++;
  endtask

  task automatic test_add();
    clear_prog();
    init_bank();
    bank[1] = 32'd2;
    bank[2] = 32'd3;
    prog[0] = 32'h0022_1820;
    run_prog("add", 0, 0, 0);
    total++;
    if (bank[3] !== 32'd5) $display("FAIL add_result: got %h want 5", bank[3]);
    else passed++;
  endtask

  task automatic test_rd_zero();
    clear_prog();
    init_bank();
    prog[0] = 32'h0000_0020;
    run_prog("rd_zero", 0, 1, 0);
  endtask

  task automatic test_illegal_restart();
    clear_prog();
    init_bank();
    prog[0] = 32'h8C01_0000;
    run_prog("illegal", 0, 2, 1);
    total++;
    if ({busy, illegal} !== 2'b01) $display("FAIL illegal_halt: got busy/illegal=%b want 01", {busy, illegal});
    else passed++;
    prog[0] = rand_legal();
    prog[1] = rand_legal();
    run_prog("restart", 0, 2, 1);
  endtask

  task automatic test_prog_len();
    int cyc = 0;
    int n_we = 0;
    int bad = 0;
    bus2.imem_data = 32'h0022_1820;
    bus2.alu_res   = 32'h0000_0011;
    bus2.imem_ack  = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (busy2 === 1'b1 && cyc < 100) begin
      bus2.imem_ack = bus2.imem_req;
      if (bus2.we_ctrl === 1'b1) begin
        n_we++;
        total++;
        if (bus2.wa_ctrl !== 5'd3 || bus2.dw_ctrl !== 32'h11)
          $display("FAIL plen_write: got wa=%0d dw=%h want wa=3 dw=11", bus2.wa_ctrl, bus2.dw_ctrl);
        else passed++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != 8 || n_we != 2)
      $display("FAIL plen_halt: got %0d cycles %0d writes want 8 cycles 2 writes", cyc, n_we);
    else passed++;
    total++;
    if (count2 !== 16'd2 || illegal2 !== 1'b0 || bus2.imem_addr !== 8'd8)
      $display("FAIL plen_state: got cnt=%0d illegal=%b pc=%0d want 2 0 8", count2, illegal2, bus2.imem_addr);
    else passed++;
    repeat (5) begin
      bus2.imem_ack = 1'b1;
      @(negedge clk);
      if (bus2.imem_req !== 1'b0 || busy2 !== 1'b0 || count2 !== 16'd2) bad++;
    end
    bus2.imem_ack = 1'b0;
    total++;
    if (bad != 0) $display("FAIL plen_req_low: got %0d active cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_ack_wait();
    clear_prog();
    init_bank();
    for (int i = 0; i < 4; i++) prog[i] = rand_legal();
    run_prog("ack_wait", 3, 3, 1);
  endtask

  task automatic test_back_to_back();
    init_bank();
    for (int i = 0; i < 64; i++) prog[i] = rand_legal();
    run_prog("b2b_full", 0, 3, 1);
  endtask

  task automatic test_random_illegal();
    repeat (3) begin
      init_bank();
      for (int i = 0; i < 64; i++) prog[i] = rand_legal();
      prog[$urandom_range(12, 1)] = rand_illegal();
      run_prog("rand_illegal", 0, 2, 1);
    end
  endtask

  task automatic test_reset_writeback();
    int cyc = 0;
    clear_prog();
    init_bank();
    prog[0] = 32'h0022_1820;
    bus.imem_ack = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (bus.we_ctrl !== 1'b1 && cyc < 50) begin
      bus.imem_ack  = bus.imem_req;
      bus.imem_data = prog[0];
      @(negedge clk);
      cyc++;
    end
    bus.imem_ack = 1'b0;
    total++;
    if (bus.we_ctrl !== 1'b1) $display("FAIL rst_wb_reach: got WE=%b want 1", bus.we_ctrl);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.imem_req, bus.imem_addr, bus.ra1_ctrl, bus.ra2_ctrl, bus.alu_op_ctrl, bus.wa_ctrl,
         bus.dw_ctrl, bus.we_ctrl, busy, illegal, count} !== '0)
      $display("FAIL rst_wb_async: got we=%b wa=%0d dw=%h busy=%b cnt=%0d want all 0",
               bus.we_ctrl, bus.wa_ctrl, bus.dw_ctrl, busy, count);
    else passed++;
    start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, bus.imem_req, bus.we_ctrl} !== 3'b000)
      $display("FAIL rst_start_ignored: got busy/req/we=%b want 000", {busy, bus.imem_req, bus.we_ctrl});
    else passed++;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, bus.imem_req} !== 2'b00) $display("FAIL rst_idle: got busy/req=%b want 00", {busy, bus.imem_req});
    else passed++;
    clear_prog();
    init_bank();
    prog[0] = rand_legal();
    run_prog("after_reset", 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_rd_zero();
    test_illegal_restart();
    test_prog_len();
    test_ack_wait();
    test_back_to_back();
    test_random_illegal();
    test_reset_writeback();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
